// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan block: glyph codes, segment
// patterns and the load handshake state encoding.
package seg7_pkg;

  localparam int CODE_W = 6;
  localparam int SEG_W  = 7;

  // Hex digits occupy codes 0-15 directly
  localparam logic [CODE_W-1:0] CODE_0     = 6'd0;
  localparam logic [CODE_W-1:0] CODE_1     = 6'd1;
  localparam logic [CODE_W-1:0] CODE_2     = 6'd2;
  localparam logic [CODE_W-1:0] CODE_3     = 6'd3;
  localparam logic [CODE_W-1:0] CODE_4     = 6'd4;
  localparam logic [CODE_W-1:0] CODE_5     = 6'd5;
  localparam logic [CODE_W-1:0] CODE_6     = 6'd6;
  localparam logic [CODE_W-1:0] CODE_7     = 6'd7;
  localparam logic [CODE_W-1:0] CODE_8     = 6'd8;
  localparam logic [CODE_W-1:0] CODE_9     = 6'd9;
  localparam logic [CODE_W-1:0] CODE_A     = 6'd10;
  localparam logic [CODE_W-1:0] CODE_B     = 6'd11;
  localparam logic [CODE_W-1:0] CODE_C     = 6'd12;
  localparam logic [CODE_W-1:0] CODE_D     = 6'd13;
  localparam logic [CODE_W-1:0] CODE_E     = 6'd14;
  localparam logic [CODE_W-1:0] CODE_F     = 6'd15;
  localparam logic [CODE_W-1:0] CODE_R     = 6'd16;
  localparam logic [CODE_W-1:0] CODE_L     = 6'd17;
  localparam logic [CODE_W-1:0] CODE_DASH  = 6'd18;
  localparam logic [CODE_W-1:0] CODE_Q     = 6'd19;
  localparam logic [CODE_W-1:0] CODE_S     = 6'd20;
  localparam logic [CODE_W-1:0] CODE_H     = 6'd21;
  localparam logic [CODE_W-1:0] CODE_T     = 6'd22;
  localparam logic [CODE_W-1:0] CODE_N     = 6'd23;
  localparam logic [CODE_W-1:0] CODE_U     = 6'd24;
  localparam logic [CODE_W-1:0] CODE_G     = 6'd25;
  localparam logic [CODE_W-1:0] CODE_RSVD0 = 6'd26;
  localparam logic [CODE_W-1:0] CODE_BLANK = 6'd63;

  // Segments are active-low, ordered gfedcba
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } load_state_t;

  function automatic logic code_is_reserved(input logic [CODE_W-1:0] code);
    return (code >= CODE_RSVD0);
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph decoder: 6-bit display code to active-low gfedcba.
// Reserved codes and anything unmapped decode to all segments off.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [SEG_W-1:0]  o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    if (!code_is_reserved(i_code)) begin
      case (i_code)
        CODE_0:    o_seg = 7'b1000000;
        CODE_1:    o_seg = 7'b1111001;
        CODE_2:    o_seg = 7'b0100100;
        CODE_3:    o_seg = 7'b0110000;
        CODE_4:    o_seg = 7'b0011001;
        CODE_5:    o_seg = 7'b0010010;
        CODE_6:    o_seg = 7'b0000010;
        CODE_7:    o_seg = 7'b1111000;
        CODE_8:    o_seg = 7'b0000000;
        CODE_9:    o_seg = 7'b0010000;
        CODE_A:    o_seg = 7'b0001000;
        CODE_B:    o_seg = 7'b0000011;
        CODE_C:    o_seg = 7'b1000110;
        CODE_D:    o_seg = 7'b0100001;
        CODE_E:    o_seg = 7'b0000110;
        CODE_F:    o_seg = 7'b0001110;
        // Letters share hex shapes where the display cannot tell them apart
        CODE_R:    o_seg = 7'b0101111;
        CODE_L:    o_seg = 7'b1000111;
        CODE_DASH: o_seg = 7'b0111111;
        CODE_Q:    o_seg = 7'b0011000;
        CODE_S:    o_seg = 7'b0010010;
        CODE_H:    o_seg = 7'b0001001;
        CODE_T:    o_seg = 7'b0000111;
        CODE_N:    o_seg = 7'b0101011;
        CODE_U:    o_seg = 7'b1100011;
        CODE_G:    o_seg = 7'b0010000;
        default:   o_seg = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Multi-digit seven-segment driver: frame load handshake with staging,
// frame-aligned commit, leading-zero blanking, blink and multiplexed scan.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [NUM_DIGITS*CODE_W-1:0] load_digits,
  input  logic [NUM_DIGITS-1:0]        load_blink,
  input  logic                         lz_suppress,
  output logic [NUM_DIGITS*SEG_W-1:0]  hex_par,
  output logic [SEG_W-1:0]             scan_seg,
  output logic [NUM_DIGITS-1:0]        scan_an
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  localparam logic [IDX_W-1:0]   DIG_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  load_state_t                   r_state;
  logic                          r_load_ready;
  logic [NUM_DIGITS*CODE_W-1:0]  r_stage_codes;
  logic [NUM_DIGITS-1:0]         r_stage_blink;
  logic [NUM_DIGITS*CODE_W-1:0]  r_disp_codes;
  logic [NUM_DIGITS-1:0]         r_disp_blink;

  logic [PRESC_W-1:0]            r_presc;
  logic [IDX_W-1:0]              r_scan_idx;
  logic [BLINK_W-1:0]            r_blink_cnt;
  logic                          r_blink_phase;

  logic [NUM_DIGITS*SEG_W-1:0]   r_hex_par;
  logic [SEG_W-1:0]              r_scan_seg;
  logic [NUM_DIGITS-1:0]         r_scan_an;

  logic                          w_tick;
  logic                          w_frame_tick;
  logic [NUM_DIGITS-1:0]         w_lz_blank;
  logic                          w_lz_run;
  logic [NUM_DIGITS*SEG_W-1:0]   w_hex_next;
  logic [SEG_W-1:0]              w_scan_seg_next;
  logic [NUM_DIGITS-1:0]         w_scan_an_next;

  assign w_tick       = (r_presc == PRESC_LAST);
  assign w_frame_tick = w_tick && (r_scan_idx == DIG_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc       <= '0;
      r_scan_idx    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_scan_idx <= (r_scan_idx == DIG_LAST) ? '0 : r_scan_idx + 1'b1;
      end
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Commit waits for a frame wrap so a new frame never tears mid-scan
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_load_ready  <= 1'b0;
      r_stage_codes <= {NUM_DIGITS{CODE_BLANK}};
      r_stage_blink <= '0;
      r_disp_codes  <= {NUM_DIGITS{CODE_BLANK}};
      r_disp_blink  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_load_ready <= 1'b1;
          if (load_valid && r_load_ready) begin
            r_stage_codes <= load_digits;
            r_stage_blink <= load_blink;
            r_load_ready  <= 1'b0;
            r_state       <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (w_frame_tick) begin
            r_disp_codes <= r_stage_codes;
            r_disp_blink <= r_stage_blink;
            r_load_ready <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_load_ready <= 1'b0;
        end
      endcase
    end
  end

  // Zero run is tracked from the most significant digit down; digit 0 is exempt
  always_comb begin
    w_lz_blank = '0;
    w_lz_run   = lz_suppress;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_lz_run      = w_lz_run & (r_disp_codes[i*CODE_W +: CODE_W] == CODE_0);
      w_lz_blank[i] = w_lz_run;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [SEG_W-1:0] w_glyph;

    seg7_glyph u_glyph (
      .i_code (r_disp_codes[gi*CODE_W +: CODE_W]),
      .o_seg  (w_glyph)
    );

    assign w_hex_next[gi*SEG_W +: SEG_W] =
      (w_lz_blank[gi] | (r_disp_blink[gi] & r_blink_phase)) ? SEG_OFF : w_glyph;
    assign w_scan_an_next[gi] = (r_scan_idx != IDX_W'(gi));
  end

  always_comb begin
    w_scan_seg_next = SEG_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_scan_idx == IDX_W'(i)) begin
        w_scan_seg_next = w_hex_next[i*SEG_W +: SEG_W];
      end
    end
  end

  // Scan select and scanned segments come from the same index, so they stay aligned
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hex_par  <= {NUM_DIGITS{SEG_OFF}};
      r_scan_seg <= SEG_OFF;
      r_scan_an  <= '1;
    end else begin
      r_hex_par  <= w_hex_next;
      r_scan_seg <= w_scan_seg_next;
      r_scan_an  <= w_scan_an_next;
    end
  end

  assign load_ready = r_load_ready;
  assign hex_par    = r_hex_par;
  assign scan_seg   = r_scan_seg;
  assign scan_an    = r_scan_an;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: a cycle-count based reference model
// compared every cycle, plus literal checks on the key scenarios.
module tb_seg7_scan;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BD    = 16;
  localparam int FRAME = ND * SD;
  localparam int LIMIT = 200;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            load_valid;
  logic            load_ready;
  logic [ND*6-1:0] load_digits;
  logic [ND-1:0]   load_blink;
  logic            lz_suppress;
  logic [ND*7-1:0] hex_par;
  logic [6:0]      scan_seg;
  logic [ND-1:0]   scan_an;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  seg7_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_digits (load_digits),
    .load_blink  (load_blink),
    .lz_suppress (lz_suppress),
    .hex_par     (hex_par),
    .scan_seg    (scan_seg),
    .scan_an     (scan_an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int c);
    case (c)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
      3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
     12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;
     15: return 7'b0001110;  16: return 7'b0101111;  17: return 7'b1000111;
     18: return 7'b0111111;  19: return 7'b0011000;  20: return 7'b0010010;
     21: return 7'b0001001;  22: return 7'b0000111;  23: return 7'b0101011;
     24: return 7'b1100011;  25: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: counters are pure functions of cycles since reset release
  int            m_disp [ND];
  int            m_stage[ND];
  logic [ND-1:0] m_disp_blink, m_stage_blink;
  bit            m_pending;
  int            m_cyc;
  logic [ND*7-1:0] e_hex   = '1;
  logic [6:0]      e_seg   = '1;
  logic [ND-1:0]   e_an    = '1;
  logic            e_ready = 1'b0;

  always @(posedge clk or negedge reset_n) begin : model
    int idx, phase;
    logic [6:0] seg;
    bit lead;
    if (!reset_n) begin
      for (int d = 0; d < ND; d++) begin
        m_disp[d]  = 63;
        m_stage[d] = 63;
      end
      m_disp_blink  = '0;
      m_stage_blink = '0;
      m_pending     = 1'b0;
      m_cyc         = 0;
      e_hex         = '1;
      e_seg         = '1;
      e_an          = '1;
      e_ready       = 1'b0;
    end else begin
      idx   = (m_cyc / SD) % ND;
      phase = (m_cyc / BD) % 2;
      for (int d = 0; d < ND; d++) begin
        seg  = glyph(m_disp[d]);
        lead = (d > 0) && lz_suppress;
        for (int j = d; j < ND; j++) if (m_disp[j] != 0) lead = 1'b0;
        if (lead || (m_disp_blink[d] && phase == 1)) seg = 7'b1111111;
        e_hex[d*7 +: 7] = seg;
      end
      e_an      = '1;
      e_an[idx] = 1'b0;
      e_seg     = e_hex[idx*7 +: 7];
      if (m_pending) begin
        if (m_cyc % FRAME == FRAME - 1) begin
          m_disp       = m_stage;
          m_disp_blink = m_stage_blink;
          m_pending    = 1'b0;
        end
      end else if (e_ready && load_valid) begin
        for (int d = 0; d < ND; d++) m_stage[d] = int'(load_digits[d*6 +: 6]);
        m_stage_blink = load_blink;
        m_pending     = 1'b1;
      end
      e_ready = !m_pending;
      m_cyc++;
    end
  end

  always @(posedge clk) begin
    #3;
    if (chk_en) begin
      chk("cyc_hex_par",    32'(hex_par),    32'(e_hex));
      chk("cyc_scan_seg",   32'(scan_seg),   32'(e_seg));
      chk("cyc_scan_an",    32'(scan_an),    32'(e_an));
      chk("cyc_load_ready", 32'(load_ready), 32'(e_ready));
    end
  end

  // Offer a frame when ready, then wait for its commit to reach hex_par
  task automatic load_frame(input logic [ND*6-1:0] dig, input logic [ND-1:0] bl, input bit churn);
    int t;
    t = 0;
    while (!load_ready && t < LIMIT) begin @(negedge clk); t++; end
    chk("wait_ready_in", 32'(t < LIMIT), 32'd1);
    load_valid  = 1'b1;
    load_digits = dig;
    load_blink  = bl;
    @(negedge clk);
    if (!churn) load_valid = 1'b0;
    t = 0;
    while (!load_ready && t < LIMIT) begin
      if (churn) begin
        load_digits = 24'($urandom);
        load_blink  = 4'($urandom);
      end
      @(negedge clk);
      t++;
    end
    load_valid = 1'b0;
    chk("wait_commit", 32'(t < LIMIT), 32'd1);
    @(negedge clk);
  endtask

  function automatic logic [5:0] rand_code();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 6'd0;
    if (r == 9) return 6'($urandom_range(26, 63));
    return 6'($urandom_range(0, 25));
  endfunction

  logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    int n_off;
    reset_n     = 1'b0;
    load_valid  = 1'b0;
    load_digits = '0;
    load_blink  = '0;
    lz_suppress = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_scan_an", 32'(scan_an), 32'(4'b1111));
    chk("rst_hex_par", 32'(hex_par), 32'(28'hFFFFFFF));
    chk("rst_ready",   32'(load_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_rise", 32'(load_ready), 32'd1);
    chk("scan_seq", 32'(scan_an), 32'(an_seq[0]));
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      chk("scan_seq", 32'(scan_an), 32'(an_seq[k/4]));
    end

    load_frame({6'd8, 6'd10, 6'd1, 6'd0}, 4'b0000, 1'b0);
    chk("frame_8A10", 32'(hex_par), 32'({7'b0000000, 7'b0001000, 7'b1111001, 7'b1000000}));
    chk("ready_after_commit", 32'(load_ready), 32'd1);

    lz_suppress = 1'b1;
    load_frame({6'd0, 6'd0, 6'd3, 6'd0}, 4'b0000, 1'b0);
    chk("lz_on", 32'(hex_par), 32'({7'b1111111, 7'b1111111, 7'b0110000, 7'b1000000}));
    lz_suppress = 1'b0;
    @(negedge clk);
    chk("lz_off", 32'(hex_par), 32'({7'b1000000, 7'b1000000, 7'b0110000, 7'b1000000}));

    load_frame({6'd1, 6'd2, 6'd3, 6'd4}, 4'b0100, 1'b0);
    n_off = 0;
    for (int k = 0; k < 64; k++) begin
      if (hex_par[14 +: 7] == 7'b1111111) n_off++;
      @(negedge clk);
    end
    chk("blink_half_off", 32'(n_off), 32'd32);

    load_frame({6'd30, 6'd63, 6'd5, 6'd2}, 4'b0000, 1'b1);
    chk("first_frame_kept", 32'(hex_par), 32'({7'b1111111, 7'b1111111, 7'b0010010, 7'b0100100}));

    begin
      int t;
      t = 0;
      while (!load_ready && t < LIMIT) begin @(negedge clk); t++; end
      chk("wait_ready_pend", 32'(t < LIMIT), 32'd1);
    end
    load_valid  = 1'b1;
    load_digits = {6'd8, 6'd8, 6'd8, 6'd8};
    load_blink  = '0;
    @(negedge clk);
    load_valid = 1'b0;
    chk("pend_ready_low", 32'(load_ready), 32'd0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_scan_an", 32'(scan_an), 32'(4'b1111));
    chk("rst2_scan_seg", 32'(scan_seg), 32'(7'b1111111));
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_commit_after_rst", 32'(hex_par), 32'(28'hFFFFFFF));

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      load_valid = ($urandom_range(0, 3) == 0);
      for (int d = 0; d < ND; d++) load_digits[d*6 +: 6] = rand_code();
      load_blink = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 15) == 0) lz_suppress = ~lz_suppress;
    end
    load_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
